// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. Two-flop synchroniser on rx, falling-edge
//                start detection, mid-bit sampling of START / DATA (LSB
//                first) / STOP, and a one-entry valid/ready output register.
//                Optional macro UART_RX_ERROR_FLAGS_EN adds the
//                framing_error and overrun pulse outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int BAUD_DIVIDER   = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rx,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic [NUMBER_OF_BITS-1:0] data_bits
`ifdef UART_RX_ERROR_FLAGS_EN
    ,
    output logic                      framing_error,
    output logic                      overrun
`endif
);

    localparam int c_rate_w = $clog2(BAUD_DIVIDER);
    localparam int c_bit_w  = $clog2(NUMBER_OF_BITS + 1);

    localparam logic [c_rate_w-1:0] c_rate_half = c_rate_w'(BAUD_DIVIDER / 2 - 1);
    localparam logic [c_rate_w-1:0] c_rate_full = c_rate_w'(BAUD_DIVIDER - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(NUMBER_OF_BITS - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic                      r_rx_meta;
    logic                      r_rx_s;
    logic                      r_rx_prev;
    logic [1:0]                r_state;
    logic [1:0]                w_next_state;
    logic [c_rate_w-1:0]       r_rate_cnt;
    logic [c_bit_w-1:0]        r_bit_cnt;
    logic [NUMBER_OF_BITS-1:0] r_shift;

    logic w_rate_zero;
    logic w_start_detect;
    logic w_start_ok;
    logic w_data_sample;
    logic w_stop_sample;
    logic w_count_down;
    logic w_accept;
    logic w_load;

    // Synchronise rx; r_rx_prev keeps the previous synchronised value so that
    // only a real falling edge (not a held-low break) can begin a frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (!r_rx_s && r_rx_prev) begin
                    w_next_state = c_st_start;
                end
            end
            c_st_start: begin
                if (w_rate_zero) begin
                    w_next_state = r_rx_s ? c_st_idle : c_st_data;
                end
            end
            c_st_data: begin
                if (w_rate_zero && (r_bit_cnt == c_bit_last)) begin
                    w_next_state = c_st_stop;
                end
            end
            c_st_stop: begin
                if (w_rate_zero) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // FSM output decode: sampling strobes and handshake qualifiers.
    always_comb begin
        w_rate_zero    = (r_rate_cnt == '0);
        w_start_detect = (r_state == c_st_idle) && !r_rx_s && r_rx_prev;
        w_start_ok     = (r_state == c_st_start) && w_rate_zero && !r_rx_s;
        w_data_sample  = (r_state == c_st_data) && w_rate_zero;
        w_stop_sample  = (r_state == c_st_stop) && w_rate_zero;
        w_count_down   = (r_state != c_st_idle) && !w_rate_zero;
        w_accept       = data_valid && data_ready;
        // A same-cycle accept frees the register, so the new word may load.
        w_load         = w_stop_sample && r_rx_s && (!data_valid || w_accept);
    end

    // Baud-rate and bit counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rate_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            if (w_start_detect) begin
                r_rate_cnt <= c_rate_half;
                r_bit_cnt  <= '0;
            end else if (w_start_ok) begin
                r_rate_cnt <= c_rate_full;
                r_bit_cnt  <= '0;
            end else if (w_data_sample) begin
                r_rate_cnt <= c_rate_full;
                r_bit_cnt  <= r_bit_cnt + 1'b1;
            end else if (w_count_down) begin
                r_rate_cnt <= r_rate_cnt - 1'b1;
            end
        end
    end

    // Shift register: each data sample enters at the MSB and shifts right,
    // so the first bit on the line ends up in bit 0.
    generate
        if (NUMBER_OF_BITS == 1) begin : g_shift_single
            // Single-bit word: the sample is the whole word.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_shift <= '0;
                end else if (w_data_sample) begin
                    r_shift <= r_rx_s;
                end
            end
        end else begin : g_shift_multi
            // Multi-bit word: shift right with the new sample at the MSB.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_shift <= '0;
                end else if (w_data_sample) begin
                    r_shift <= {r_rx_s, r_shift[NUMBER_OF_BITS-1:1]};
                end
            end
        end
    endgenerate

    // One-entry output register with valid/ready handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_valid <= 1'b0;
            data_bits  <= '0;
        end else if (w_load) begin
            data_valid <= 1'b1;
            data_bits  <= r_shift;
        end else if (w_accept) begin
            data_valid <= 1'b0;
        end
    end

`ifdef UART_RX_ERROR_FLAGS_EN
    // One-cycle error pulses following a bad stop bit or a dropped word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= w_stop_sample && !r_rx_s;
            overrun       <= w_stop_sample && r_rx_s && data_valid && !w_accept;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx (8 data bits, divider 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int N   = 8;
    localparam int DIV = 4;

    logic         clock      = 1'b0;
    logic         reset_n    = 1'b0;
    logic         rx         = 1'b1;
    logic         data_ready = 1'b1;
    logic         data_valid;
    logic [N-1:0] data_bits;
`ifdef UART_RX_ERROR_FLAGS_EN
    logic         framing_error;
    logic         overrun;
`endif

    uart_rx #(
        .NUMBER_OF_BITS(N),
        .BAUD_DIVIDER  (DIV)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rx           (rx),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data_bits    (data_bits)
`ifdef UART_RX_ERROR_FLAGS_EN
        ,
        .framing_error(framing_error),
        .overrun      (overrun)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Observer: records accepted words, valid rising edges and error pulses.
    logic [N-1:0] got[$];
    int           ferr_cnt   = 0;
    int           ovr_cnt    = 0;
    int           rise_cyc   = 0;
    logic         prev_valid = 1'b0;
    always @(negedge clock) begin
        if (data_valid && data_ready) got.push_back(data_bits);
        if (data_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = data_valid;
`ifdef UART_RX_ERROR_FLAGS_EN
        if (framing_error) ferr_cnt++;
        if (overrun) ovr_cnt++;
`endif
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change 2 ns after the rising edge, well away from it.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (DIV) tick();
    endtask

    task automatic send_frame(input logic [N-1:0] d, input logic stop_b);
        logic [N-1:0] v;
        v = d;
        send_bit(1'b0);
        for (int i = 0; i < N; i++) send_bit(v[i]);
        send_bit(stop_b);
        rx = 1'b1;
    endtask

    function automatic int word_at(input int idx);
        if (idx < got.size()) return int'(got[idx]);
        return -1;
    endfunction

    typedef struct {
        logic [N-1:0] data;
        logic         stop_b;
        int           exp_words;
        logic [N-1:0] exp_data;
        int           exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base;
        int fbase;
        int obase;
        int fall_cyc;

        vecs[0] = '{data: 8'h3C, stop_b: 1'b0, exp_words: 0, exp_data: 8'h00, exp_ferr: 1};
        vecs[1] = '{data: 8'h00, stop_b: 1'b1, exp_words: 1, exp_data: 8'h00, exp_ferr: 0};
        vecs[2] = '{data: 8'hFF, stop_b: 1'b1, exp_words: 1, exp_data: 8'hFF, exp_ferr: 0};
        vecs[3] = '{data: 8'h01, stop_b: 1'b1, exp_words: 1, exp_data: 8'h01, exp_ferr: 0};
        vecs[4] = '{data: 8'h80, stop_b: 1'b1, exp_words: 1, exp_data: 8'h80, exp_ferr: 0};
        vecs[5] = '{data: 8'hC3, stop_b: 1'b1, exp_words: 1, exp_data: 8'hC3, exp_ferr: 0};

        // Reset state
        idle(3);
        check("reset_valid", int'(data_valid), 0);
        check("reset_bits", int'(data_bits), 0);
`ifdef UART_RX_ERROR_FLAGS_EN
        check("reset_ferr", int'(framing_error), 0);
        check("reset_ovr", int'(overrun), 0);
`endif
        reset_n = 1'b1;
        idle(4);

        // Single frame 0xA5, ready high: one word, latency 2+2+36+1 = 41
        base     = got.size();
        fall_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        idle(6);
        check("a5_words", got.size() - base, 1);
        check("a5_data", word_at(base), 8'hA5);
        check("a5_latency", rise_cyc - fall_cyc, 41);

        // Table of single frames
        for (int k = 0; k < 6; k++) begin
            base  = got.size();
            fbase = ferr_cnt;
            send_frame(vecs[k].data, vecs[k].stop_b);
            idle(8);
            check($sformatf("vec%0d_words", k), got.size() - base, vecs[k].exp_words);
            if (vecs[k].exp_words > 0)
                check($sformatf("vec%0d_data", k), word_at(base), int'(vecs[k].exp_data));
            check($sformatf("vec%0d_valid_idle", k), int'(data_valid), 0);
`ifdef UART_RX_ERROR_FLAGS_EN
            check($sformatf("vec%0d_ferr", k), ferr_cnt - fbase, vecs[k].exp_ferr);
`endif
        end

        // Glitch: one clock low, then high -> START aborts silently
        base  = got.size();
        fbase = ferr_cnt;
        rx    = 1'b0;
        tick();
        rx    = 1'b1;
        idle(50);
        check("glitch_words", got.size() - base, 0);
        check("glitch_valid", int'(data_valid), 0);
`ifdef UART_RX_ERROR_FLAGS_EN
        check("glitch_ferr", ferr_cnt - fbase, 0);
`endif

        // Overrun: ready low, 0x11 then 0x22 back-to-back
        base       = got.size();
        obase      = ovr_cnt;
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(6);
        check("ovr_valid_held", int'(data_valid), 1);
        check("ovr_bits_held", int'(data_bits), 8'h11);
        check("ovr_no_accept", got.size() - base, 0);
`ifdef UART_RX_ERROR_FLAGS_EN
        check("ovr_pulse", ovr_cnt - obase, 1);
`endif
        data_ready = 1'b1;
        idle(3);
        check("ovr_accept_words", got.size() - base, 1);
        check("ovr_accept_data", word_at(base), 8'h11);
        check("ovr_valid_drop", int'(data_valid), 0);
        idle(50);
        check("ovr_no_more", got.size() - base, 1);

        // Reset mid-frame: pending 0x33 plus partial 0x77 are both discarded
        base       = got.size();
        data_ready = 1'b0;
        send_frame(8'h33, 1'b1);
        idle(4);
        check("rst_pending_valid", int'(data_valid), 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rx = 1'b0;
        idle(2);
        reset_n = 1'b0;
        rx      = 1'b1;
        #1;
        check("rst_async_valid", int'(data_valid), 0);
        check("rst_async_bits", int'(data_bits), 0);
        data_ready = 1'b1;
        idle(3);
        reset_n = 1'b1;
        idle(60);
        check("rst_no_word", got.size() - base, 0);
        send_frame(8'h5A, 1'b1);
        idle(6);
        check("rst_next_words", got.size() - base, 1);
        check("rst_next_data", word_at(base), 8'h5A);

        // Back-to-back frames, no idle gap
        base  = got.size();
        fbase = ferr_cnt;
        obase = ovr_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(8);
        check("b2b_words", got.size() - base, 3);
        check("b2b_data0", word_at(base), 8'h00);
        check("b2b_data1", word_at(base + 1), 8'hFF);
        check("b2b_data2", word_at(base + 2), 8'h55);
`ifdef UART_RX_ERROR_FLAGS_EN
        check("b2b_ferr", ferr_cnt - fbase, 0);
        check("b2b_ovr", ovr_cnt - obase, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
